// File: rtl/month_year.sv
// month_year: BCD month (01..12) and 4-digit BCD year (0000..9999) counter.
// This block receives the day counter's day-to-month carry. It feeds the
// month/year digits back so the day block can decide month length and leap
// years. A validated load port lets the set-time UI write month/year directly.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   dd_to_mm_en         : one-cycle carry from the day block (advance month)
//   set_en              : one-cycle load strobe
//   set_month_1/0       : BCD month digits to load
//   set_year_3..0       : BCD year digits to load
//   month_1/0           : current BCD month
//   year_3..0           : current BCD year
//   mm_to_yy_en         : combinational, carry arriving while month == 12
//   century_wrap        : combinational, mm_to_yy_en while year == 9999
//   set_err             : registered one-cycle pulse, load rejected
//
// Per-cycle priority: rst > set_en > dd_to_mm_en. If a carry arrives in the
// same cycle as a load, the carry is dropped whether the load was accepted
// or rejected.

// One BCD digit of the year ripple. A value of 9 or above wraps to 0, so the
// digit cannot leave 0..9.
module month_year_bcd_digit (
  input  logic [3:0] cur,
  input  logic       ci,
  output logic [3:0] nxt,
  output logic       co
);
  always_comb begin
    nxt = cur;
    co  = 1'b0;
    if (ci) begin
      if (cur >= 4'd9) begin
        nxt = 4'd0;
        co  = 1'b1;
      end else begin
        nxt = cur + 4'd1;
      end
    end
  end
endmodule

module month_year #(
  parameter logic [3:0] RST_MONTH_1 = 4'd0,
  parameter logic [3:0] RST_MONTH_0 = 4'd1,
  parameter logic [3:0] RST_YEAR_3  = 4'd2,
  parameter logic [3:0] RST_YEAR_2  = 4'd0,
  parameter logic [3:0] RST_YEAR_1  = 4'd0,
  parameter logic [3:0] RST_YEAR_0  = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dd_to_mm_en,
  input  logic       set_en,
  input  logic [3:0] set_month_1,
  input  logic [3:0] set_month_0,
  input  logic [3:0] set_year_3,
  input  logic [3:0] set_year_2,
  input  logic [3:0] set_year_1,
  input  logic [3:0] set_year_0,
  output logic [3:0] month_1,
  output logic [3:0] month_0,
  output logic [3:0] year_3,
  output logic [3:0] year_2,
  output logic [3:0] year_1,
  output logic [3:0] year_0,
  output logic       mm_to_yy_en,
  output logic       century_wrap,
  output logic       set_err
);

  localparam int YDIG = 4;

  logic [3:0]            m1_q, m0_q;
  logic [YDIG-1:0][3:0]  year_q;   // [3] thousands .. [0] units
  logic [YDIG-1:0][3:0]  year_d;
  logic [YDIG:0]         ycarry;
  logic [3:0]            m1_d, m0_d;
  logic                  month_is_12;
  logic                  year_is_9999;
  logic                  load_ok;
  logic [YDIG-1:0][3:0]  set_year;

  assign set_year = {set_year_3, set_year_2, set_year_1, set_year_0};

  assign month_is_12  = (m1_q == 4'd1) && (m0_q == 4'd2);
  assign year_is_9999 = (year_q == {4'd9, 4'd9, 4'd9, 4'd9});

  // The carry outputs are zero latency, so the next stage sees the carry in
  // the same cycle as the day block's pulse.
  assign mm_to_yy_en  = dd_to_mm_en & month_is_12;
  assign century_wrap = mm_to_yy_en & year_is_9999;

  // Year ripple: the month wrap feeds the units digit, and each digit's
  // carry-out feeds the next digit.
  assign ycarry[0] = mm_to_yy_en;
  generate
    for (genvar g = 0; g < YDIG; g++) begin : g_ydig
      month_year_bcd_digit u_dig (
        .cur (year_q[g]),
        .ci  (ycarry[g]),
        .nxt (year_d[g]),
        .co  (ycarry[g+1])
      );
    end
  endgenerate

  // Month successor. The 09 case is the only one that moves the tens digit
  // upward, and 12 wraps to 01.
  always_comb begin
    m1_d = m1_q;
    m0_d = m0_q;
    if (month_is_12) begin
      m1_d = 4'd0;
      m0_d = 4'd1;
    end else if (m0_q >= 4'd9) begin
      m1_d = 4'd1;
      m0_d = 4'd0;
    end else begin
      m0_d = m0_q + 4'd1;
    end
  end

  // Load validation. Every digit must be a BCD digit, and the month must be
  // in 01..12.
  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < YDIG; i++)
      if (set_year[i] > 4'd9) load_ok = 1'b0;
    if (set_month_1 > 4'd1) load_ok = 1'b0;
    if (set_month_0 > 4'd9) load_ok = 1'b0;
    if (set_month_1 == 4'd0 && set_month_0 == 4'd0) load_ok = 1'b0;
    if (set_month_1 == 4'd1 && set_month_0 > 4'd2) load_ok = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m1_q    <= RST_MONTH_1;
      m0_q    <= RST_MONTH_0;
      year_q  <= {RST_YEAR_3, RST_YEAR_2, RST_YEAR_1, RST_YEAR_0};
      set_err <= 1'b0;
    end else if (set_en) begin
      set_err <= ~load_ok;
      if (load_ok) begin
        m1_q   <= set_month_1;
        m0_q   <= set_month_0;
        year_q <= set_year;
      end
    end else begin
      set_err <= 1'b0;
      if (dd_to_mm_en) begin
        m1_q   <= m1_d;
        m0_q   <= m0_d;
        year_q <= year_d;
      end
    end
  end

  assign month_1 = m1_q;
  assign month_0 = m0_q;
  assign year_3  = year_q[3];
  assign year_2  = year_q[2];
  assign year_1  = year_q[1];
  assign year_0  = year_q[0];

endmodule

// File: doc/month_year.md
Name: month_year

Overview:
- Receiving end of the day counter's day-to-month carry (`dd_to_mm_en`).
- Advances a BCD month (01–12) on each carry and a 4-digit BCD year (0000–9999) on each month rollover.
- Feeds month/year digits back to the day block for month-length and leap decisions.
- Includes a validated load port so the set-time UI can write month/year directly.

Parameters:
- RST_MONTH_1, 0, reset tens digit of month (BCD)
- RST_MONTH_0, 1, reset units digit of month (BCD)
- RST_YEAR_3, 2, reset thousands digit of year
- RST_YEAR_2, 0, reset hundreds digit of year
- RST_YEAR_1, 0, reset tens digit of year
- RST_YEAR_0, 0, reset units digit of year

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- dd_to_mm_en  input  1  one-cycle carry from the day block; advance month by one
- set_en  input  1  one-cycle load strobe
- set_month_1  input  4  BCD tens of month to load
- set_month_0  input  4  BCD units of month to load
- set_year_3  input  4  BCD thousands of year to load
- set_year_2  input  4  BCD hundreds of year to load
- set_year_1  input  4  BCD tens of year to load
- set_year_0  input  4  BCD units of year to load
- month_1  output  4  BCD tens of month
- month_0  output  4  BCD units of month
- year_3  output  4  BCD thousands of year
- year_2  output  4  BCD hundreds of year
- year_1  output  4  BCD tens of year
- year_0  output  4  BCD units of year
- mm_to_yy_en  output  1  combinational: `dd_to_mm_en` while month = 12
- century_wrap  output  1  combinational: `mm_to_yy_en` while year = 9999
- set_err  output  1  registered one-cycle pulse: load rejected

Behaviour:
- Reset:
  - Digits load `RST_*` values (default 01 / 2000).
  - `set_err` = 0.
  - Reset overrides `set_en` and `dd_to_mm_en` in the same cycle.
- Priority per cycle: `rst` > `set_en` > `dd_to_mm_en`. A carry coinciding with an accepted or rejected load is dropped.
- Month advance on `dd_to_mm_en`:
  - 01..08 → units + 1.
  - 09 → 10.
  - 10 → 11.
  - 11 → 12.
  - 12 → 01 and year advances in the same edge.
- Year advance:
  - BCD ripple: `year_0` 9→0 carries to `year_1`, `year_1` to `year_2`, and so on.
  - 9999 → 0000.
  - No change to month other than the 12→01 wrap.
- Carry outputs:
  - `mm_to_yy_en` = `dd_to_mm_en` & (month == 12); no register, zero latency.
  - `century_wrap` = `mm_to_yy_en` & (year == 9999).
- Load:
  - When `set_en` = 1, validate before commit.
  - Every digit must be ≤ 9.
  - `set_month_1` must be ≤ 1.
  - Month value must be 01..12.
  - Valid: all six digits update on that edge; `set_err` stays 0.
  - Invalid: no digit changes; `set_err` = 1 for the following cycle only.
- `set_err` returns to 0 the cycle after any non-rejecting cycle, including reset.
- Outputs are never illegal: month is always 01..12 and year digits are always 0..9, regardless of stimulus.
- Back-to-back carries on consecutive cycles each advance by exactly one month.

Test Plan:
- Reset: assert `rst` 2 cycles → month = 01, year = 2000, `set_err` = 0, `mm_to_yy_en` = 0.
- Month sweep: from 01/2000, pulse `dd_to_mm_en` 11 times → months 02..12 in order, including 09→10. On the 12th pulse, `mm_to_yy_en` = 1 during the pulse cycle; next state is 01/2001.
- Year ripple: load 12/1999, pulse carry → 01/2000. Load 12/9999, pulse carry → `century_wrap` = 1 in the pulse cycle, then 01/0000.
- Load validation:
  - Load 13/2024 → state unchanged, `set_err` = 1 for exactly 1 cycle.
  - Load 00/2024 → rejected.
  - Load month 0A or year 20A4 → rejected.
  - Load 07/2024 → state = 07/2024, `set_err` = 0.
- Simultaneous events:
  - `set_en` (valid 05/2030) together with `dd_to_mm_en` at 12/2029 → state = 05/2030; carry ignored.
  - `rst` together with `set_en` → reset values win.
- Back-to-back carries: 3 consecutive `dd_to_mm_en` cycles from 11/2023 → 12/2023, then 01/2024, then 02/2024. `mm_to_yy_en` = 1 only in the second cycle.
